updown_counter_n: RTL and testbench

- Parametrised synchronous up/down counter; next generation of the 4-bit 74169-style counter.
- Adds generic width, a runtime-loadable terminal limit (programmable modulus), wrap or saturate mode, synchronous reset and a registered terminal-event pulse.
- Keeps 74169-style pin semantics (U_DB, ENPB, ENTB, LOADB, RCOB) so stages cascade RCOB -> ENTB.
- Used for timers, address sequencers and divide-by-N chains.

---
 rtl/updown_counter_n.sv | 65 ++++++
 tb/tb_updown_counter_n.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_n.sv
// Parametrised synchronous up/down counter with 74169-style control pins.
// It adds a runtime-loadable terminal limit, a wrap or saturate mode and a
// registered terminal-event pulse. Stages cascade by wiring RCOB to ENTB.
module updown_counter_n #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] LIMIT_RST = {WIDTH{1'b1}},
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic [WIDTH-1:0] A,
    input  logic             LOADB,
    input  logic             LIMLDB,
    input  logic             U_DB,
    input  logic             ENPB,
    input  logic             ENTB,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] LIMIT,
    output logic             RCOB,
    output logic             TC_EVT
);

    logic             terminal;
    logic             count_en;
    logic [WIDTH-1:0] q_next;

    // Boundary detect and ripple carry; RCOB follows direction changes in the same cycle.
    always_comb begin
        terminal = U_DB ? (Q >= LIMIT) : (Q == '0);
        count_en = LOADB & ~ENPB & ~ENTB;
        RCOB     = ~(~ENTB & terminal);
    end

    // Next counter value: a load wins over counting, then step, wrap or hold at the boundary.
    always_comb begin
        // NOTE: default first so every path assigns q_next and no latch is inferred.
        q_next = Q;
        if (!LOADB) begin
            q_next = A;
        end else if (count_en) begin
            if (U_DB) begin
                if (!terminal)     q_next = Q + 1'b1;
                else if (!SATURATE) q_next = '0;
            end else begin
                if (!terminal)     q_next = Q - 1'b1;
                else if (!SATURATE) q_next = LIMIT;
            end
        end
    end

    // State registers with synchronous active-low reset; decisions use the pre-edge LIMIT.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!RSTB) begin
            Q      <= '0;
            LIMIT  <= LIMIT_RST;
            TC_EVT <= 1'b0;
        end else begin
            Q      <= q_next;
            TC_EVT <= count_en & terminal;
            if (!LIMLDB) LIMIT <= A;
        end
    end

endmodule

// File: tb/tb_updown_counter_n.sv
// Self-checking bench for updown_counter_n: a wrap-mode and a saturate-mode
// instance share one stimulus stream; an integer reference model is compared
// every cycle, and directed steps pin the model with hand-computed values.
module tb_updown_counter_n;

    logic       CLK = 1'b0;
    logic       rstb, loadb, limldb, u_db, enpb, entb;
    logic [3:0] a;

    logic [3:0] q_w, lim_w, q_s, lim_s;
    logic       rcob_w, tc_w, rcob_s, tc_s;

    int checks = 0;
    int errors = 0;

    // Reference model state, one set per instance.
    int m_q_w = 0, m_lim_w = 15, m_tc_w = 0;
    int m_q_s = 0, m_lim_s = 15, m_tc_s = 0;

    always #5 CLK = ~CLK;

    updown_counter_n #(.WIDTH(4), .SATURATE(1'b0)) dut_w (
        .CLK(CLK), .RSTB(rstb), .A(a), .LOADB(loadb), .LIMLDB(limldb),
        .U_DB(u_db), .ENPB(enpb), .ENTB(entb),
        .Q(q_w), .LIMIT(lim_w), .RCOB(rcob_w), .TC_EVT(tc_w)
    );

    updown_counter_n #(.WIDTH(4), .SATURATE(1'b1)) dut_s (
        .CLK(CLK), .RSTB(rstb), .A(a), .LOADB(loadb), .LIMLDB(limldb),
        .U_DB(u_db), .ENPB(enpb), .ENTB(entb),
        .Q(q_s), .LIMIT(lim_s), .RCOB(rcob_s), .TC_EVT(tc_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int is_term(input int q, input int lim, input logic up);
        return up ? int'(q >= lim) : int'(q == 0);
    endfunction

    // One rising edge of the counter described by plain arithmetic on integers.
    task automatic model_step(inout int q, inout int lim, inout int tc, input bit sat);
        int t, ce, nq;
        if (!rstb) begin
            q = 0; lim = 15; tc = 0;
        end else begin
            t  = is_term(q, lim, u_db);
            ce = int'(loadb && !enpb && !entb);
            nq = q;
            if (!loadb)                nq = int'(a);
            else if (ce != 0 && u_db)  nq = (t != 0) ? (sat ? q : 0)   : (q + 1) % 16;
            else if (ce != 0 && !u_db) nq = (t != 0) ? (sat ? q : lim) : (q + 15) % 16;
            if (!limldb) lim = int'(a);
            tc = ce & t;
            q  = nq;
        end
    endtask

    // Advance the model on every edge, then compare all outputs of both instances.
    always @(posedge CLK) begin
        model_step(m_q_w, m_lim_w, m_tc_w, 1'b0);
        model_step(m_q_s, m_lim_s, m_tc_s, 1'b1);
        #2;
        check("model q_w",     q_w,    m_q_w);
        check("model limit_w", lim_w,  m_lim_w);
        check("model tc_w",    tc_w,   m_tc_w);
        check("model rcob_w",  rcob_w, 32'(!(!entb && is_term(m_q_w, m_lim_w, u_db) != 0)));
        check("model q_s",     q_s,    m_q_s);
        check("model limit_s", lim_s,  m_lim_s);
        check("model tc_s",    tc_s,   m_tc_s);
        check("model rcob_s",  rcob_s, 32'(!(!entb && is_term(m_q_s, m_lim_s, u_db) != 0)));
    end

    task automatic set_in(input bit r, input bit ld, input bit lm, input bit up,
                          input bit ep, input bit et, input logic [3:0] av);
        rstb = r; loadb = ld; limldb = lm; u_db = up; enpb = ep; entb = et; a = av;
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    initial begin
        set_in(0, 1, 1, 1, 1, 1, 4'd0);
        @(negedge CLK);
        step();

        // Reset state.
        check("rst q",     q_w,   0);
        check("rst limit", lim_w, 15);
        check("rst tc",    tc_w,  0);
        check("rst q_s",   q_s,   0);

        // Full modulo-16 up count: 0..15, 0, 1.
        set_in(1, 1, 1, 1, 0, 0, 4'd0);
        for (int i = 0; i <= 17; i++) begin
            #1;
            check("up16 q",    q_w,    i % 16);
            check("up16 rcob", rcob_w, (i == 15) ? 0 : 1);
            check("up16 tc",   tc_w,   (i == 16) ? 1 : 0);
            if (i < 17) step();
        end
        check("up16 sat q",  q_s,  15);
        check("up16 sat tc", tc_s, 1);

        // Programmable modulus 10, then reverse direction at 0.
        set_in(1, 1, 0, 1, 1, 0, 4'd9); step();
        set_in(1, 0, 1, 1, 1, 0, 4'd0); step();
        check("lim9 limit", lim_w, 9);
        set_in(1, 1, 1, 1, 0, 0, 4'd0);
        for (int i = 0; i <= 10; i++) begin
            #1;
            check("mod10 q", q_w, i % 10);
            if (i < 10) step();
        end
        check("mod10 tc", tc_w, 1);
        set_in(1, 1, 1, 0, 0, 0, 4'd0);
        #1;
        check("down at 0 rcob", rcob_w, 0);
        step();
        check("down wrap q", q_w, 9);

        // Saturate mode at LIMIT=5 from Q=4.
        set_in(1, 1, 0, 1, 1, 0, 4'd5); step();
        set_in(1, 0, 1, 1, 1, 0, 4'd4); step();
        set_in(1, 1, 1, 1, 0, 0, 4'd0);
        step(); check("sat q1", q_s, 5); check("sat tc1", tc_s, 0);
        step(); check("sat q2", q_s, 5); check("sat tc2", tc_s, 1);
        step(); check("sat q3", q_s, 5); check("sat tc3", tc_s, 1);
        check("wrap q3", q_w, 1);
        set_in(1, 0, 1, 0, 1, 0, 4'd0); step();
        set_in(1, 1, 1, 0, 0, 0, 4'd0);
        step(); check("sat down q", q_s, 0); check("sat down tc", tc_s, 1);
        #1; check("sat down rcob", rcob_s, 0);

        // Load wins over count; above-limit wrap; joint load.
        set_in(1, 1, 0, 1, 1, 0, 4'd15); step();
        set_in(1, 0, 1, 1, 0, 0, 4'd12); step();
        check("load q", q_w, 12); check("load tc", tc_w, 0);
        set_in(1, 1, 0, 1, 1, 0, 4'd9); step();
        set_in(1, 1, 1, 1, 0, 0, 4'd0); step();
        check("above lim wrap q", q_w, 0); check("above lim tc", tc_w, 1);
        check("above lim sat q", q_s, 12);
        set_in(1, 0, 0, 1, 1, 0, 4'd3); step();
        check("joint q", q_w, 3); check("joint limit", lim_w, 3);

        // ENPB blocks counting but not RCOB; ENTB forces RCOB high.
        set_in(1, 0, 0, 1, 1, 0, 4'd15); step();
        set_in(1, 1, 1, 1, 1, 0, 4'd0); step();
        #1;
        check("enp q", q_w, 15); check("enp rcob", rcob_w, 0); check("enp tc", tc_w, 0);
        set_in(1, 1, 1, 1, 0, 1, 4'd0);
        #1; check("ent rcob", rcob_w, 1);
        step(); check("ent q", q_w, 15);

        // Reset mid-count with a simultaneous load.
        set_in(1, 0, 0, 1, 1, 1, 4'd7); step();
        set_in(1, 1, 0, 1, 1, 1, 4'd9); step();
        check("pre rst q", q_w, 7); check("pre rst limit", lim_w, 9);
        set_in(0, 0, 1, 1, 0, 0, 4'd5); step();
        check("rst2 q", q_w, 0); check("rst2 limit", lim_w, 15); check("rst2 tc", tc_w, 0);

        // Randomised traffic checked by the model each cycle.
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 49) != 0, $urandom_range(0, 7) != 0,
                   $urandom_range(0, 9) != 0, 1'($urandom), $urandom_range(0, 4) == 0,
                   $urandom_range(0, 5) == 0,
                   ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
